// File: rtl/adder_rs_pkg.sv
// Shared constants and types for the adder reservation-station block.
// Unit code, ALU op codes, FSM states and default widths.
package adder_rs_pkg;
   localparam int TAG_WIDTH = 6;
   localparam int DWIDTH    = 32;
   localparam int RADDR     = 5;
   localparam int LATENCY   = 2;

   localparam logic [2:0] ADDER   = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_AND = 3'b101;
   localparam logic [2:0] ALU_NOT = 3'b110;
   localparam logic [2:0] ALU_XOR = 3'b111;

   typedef enum logic [1:0] {IDLE, EXEC, WAIT_CDB} state_t;
endpackage

// File: rtl/adder_reservation_stations_if.sv
// Issue-queue / CDB bundle between the instruction queue and the adder stations.
// slave = reservation-station side, master = queue / arbiter side.
interface adder_reservation_stations_if import adder_rs_pkg::*; #(
   parameter int NUM_RS        = TAG_WIDTH,
   parameter int DATA_WIDTH    = DWIDTH,
   parameter int REG_ADDR_BITS = RADDR
);
   logic                     issue;
   logic [5:0]               operation;
   logic [2:0]               execution_unit;
   logic [REG_ADDR_BITS-1:0] Dest_address;
   logic [REG_ADDR_BITS-1:0] A_address;
   logic [REG_ADDR_BITS-1:0] B_address;
   logic [DATA_WIDTH-1:0]    rf_A_value;
   logic [DATA_WIDTH-1:0]    rf_B_value;
   logic [NUM_RS-1:0]        rf_A_tag;
   logic [NUM_RS-1:0]        rf_B_tag;
   logic                     cdb_in_valid;
   logic [NUM_RS-1:0]        cdb_in_tag;
   logic [DATA_WIDTH-1:0]    cdb_in_value;
   logic                     cdb_grant;
   logic                     adder_available;
   logic [NUM_RS-1:0]        adder_RS_available;
   logic [NUM_RS-1:0]        RS_issued;
   logic [NUM_RS-1:0]        RS_executing_adder;
   logic                     adder_rts;
   logic [NUM_RS-1:0]        cdb_tag;
   logic [REG_ADDR_BITS-1:0] cdb_dest;
   logic [DATA_WIDTH-1:0]    cdb_value;
   logic [NUM_RS-1:0]        RS_finished;
   logic                     issue_error;

   modport slave (
      input  issue, operation, execution_unit, Dest_address,
      input  A_address, B_address, rf_A_value, rf_B_value,
      input  rf_A_tag, rf_B_tag, cdb_in_valid, cdb_in_tag,
      input  cdb_in_value, cdb_grant,
      output adder_available, adder_RS_available, RS_issued,
      output RS_executing_adder, adder_rts, cdb_tag, cdb_dest,
      output cdb_value, RS_finished, issue_error
   );

   modport master (
      output issue, operation, execution_unit, Dest_address,
      output A_address, B_address, rf_A_value, rf_B_value,
      output rf_A_tag, rf_B_tag, cdb_in_valid, cdb_in_tag,
      output cdb_in_value, cdb_grant,
      input  adder_available, adder_RS_available, RS_issued,
      input  RS_executing_adder, adder_rts, cdb_tag, cdb_dest,
      input  cdb_value, RS_finished, issue_error
   );
endinterface

// File: rtl/adder_reservation_stations_rs_entry.sv
// One adder reservation station: operands or producer tags,
// same-cycle bypass on allocation, CDB wakeup, and a ready flag.
module rs_entry import adder_rs_pkg::*; #(
   parameter int NUM_RS        = TAG_WIDTH,
   parameter int DATA_WIDTH    = DWIDTH,
   parameter int REG_ADDR_BITS = RADDR
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     alloc,
   input  logic [2:0]               op,
   input  logic [REG_ADDR_BITS-1:0] dest,
   input  logic [DATA_WIDTH-1:0]    a_value,
   input  logic [NUM_RS-1:0]        a_tag,
   input  logic [DATA_WIDTH-1:0]    b_value,
   input  logic [NUM_RS-1:0]        b_tag,
   input  logic                     ext_valid,
   input  logic [NUM_RS-1:0]        ext_tag,
   input  logic [DATA_WIDTH-1:0]    ext_value,
   input  logic                     own_valid,
   input  logic [NUM_RS-1:0]        own_tag,
   input  logic [DATA_WIDTH-1:0]    own_value,
   input  logic                     dispatch,
   input  logic                     retire,
   output logic                     busy,
   output logic                     ready,
   output logic [2:0]               alu_op,
   output logic [REG_ADDR_BITS-1:0] dest_reg,
   output logic [DATA_WIDTH-1:0]    vj,
   output logic [DATA_WIDTH-1:0]    vk
);
   logic [NUM_RS-1:0]     qj, qk, qj_n, qk_n, src_j, src_k;
   logic [DATA_WIDTH-1:0] vj_n, vk_n;
   logic                  dispatched;

   // Allocation looks at the rf inputs, otherwise at the held tags;
   // either way a matching broadcast this cycle resolves the operand.
   always_comb begin
      src_j = alloc ? a_tag : qj;
      vj_n  = alloc ? a_value : vj;
      src_k = alloc ? ((op == ALU_NOT) ? '0 : b_tag) : qk;
      vk_n  = alloc ? b_value : vk;
      qj_n  = src_j;
      qk_n  = src_k;
      if (|src_j && own_valid && src_j == own_tag) begin
         qj_n = '0;
         vj_n = own_value;
      end
      if (|src_j && ext_valid && src_j == ext_tag) begin
         qj_n = '0;
         vj_n = ext_value;
      end
      if (|src_k && own_valid && src_k == own_tag) begin
         qk_n = '0;
         vk_n = own_value;
      end
      if (|src_k && ext_valid && src_k == ext_tag) begin
         qk_n = '0;
         vk_n = ext_value;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy       <= 1'b0;
         dispatched <= 1'b0;
         alu_op     <= '0;
         dest_reg   <= '0;
         qj         <= '0;
         qk         <= '0;
         vj         <= '0;
         vk         <= '0;
      end else begin
         if (alloc) begin
            busy       <= 1'b1;
            dispatched <= 1'b0;
            alu_op     <= op;
            dest_reg   <= dest;
         end else if (retire) begin
            busy       <= 1'b0;
            dispatched <= 1'b0;
         end else if (dispatch) begin
            dispatched <= 1'b1;
         end
         if (alloc || busy) begin
            qj <= qj_n;
            qk <= qk_n;
            vj <= vj_n;
            vk <= vk_n;
         end
      end
   end

   assign ready = busy && qj == '0 && qk == '0 && !dispatched;
endmodule

// File: rtl/adder_reservation_stations.sv
// Adder reservation stations: free/ready priority pick, one
// unpipelined ALU and the result hold until the CDB grant.
module adder_reservation_stations import adder_rs_pkg::*; #(
   parameter int NUM_RS        = TAG_WIDTH,
   parameter int DATA_WIDTH    = DWIDTH,
   parameter int ADDER_LATENCY = LATENCY,
   parameter int REG_ADDR_BITS = RADDR
) (
   input logic                         clock,
   input logic                         reset_n,
   adder_reservation_stations_if.slave bus
);
   localparam int CW = (ADDER_LATENCY > 1) ? $clog2(ADDER_LATENCY) : 1;

   state_t                   state, state_n;
   logic [CW-1:0]            cnt, cnt_n;
   logic [NUM_RS-1:0]        busy, ready, free, free_pick, ready_pick;
   logic [NUM_RS-1:0]        alloc_vec, dispatch_vec, retire_vec;
   logic [DATA_WIDTH-1:0]    vj_arr [NUM_RS];
   logic [DATA_WIDTH-1:0]    vk_arr [NUM_RS];
   logic [2:0]               op_arr [NUM_RS];
   logic [REG_ADDR_BITS-1:0] dest_arr [NUM_RS];
   logic [DATA_WIDTH-1:0]    ex_vj, ex_vj_n, ex_vk, ex_vk_n;
   logic [2:0]               ex_op, ex_op_n;
   logic [NUM_RS-1:0]        ex_tag, ex_tag_n;
   logic [REG_ADDR_BITS-1:0] ex_dest, ex_dest_n;
   logic                     rts, rts_n, own_valid, issue_ok;
   logic [NUM_RS-1:0]        res_tag, res_tag_n;
   logic [REG_ADDR_BITS-1:0] res_dest, res_dest_n;
   logic [DATA_WIDTH-1:0]    res_value, res_value_n;
   logic [NUM_RS-1:0]        issued_q, exec_q, fin_q;
   logic                     err_q;
   logic                     unused_bits;

   function automatic logic [DATA_WIDTH-1:0] alu(
      input logic [2:0]            op,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      case (op)
         ALU_ADD: alu = a + b;
         ALU_SUB: alu = a - b;
         ALU_OR:  alu = a | b;
         ALU_AND: alu = a & b;
         ALU_NOT: alu = ~a;
         ALU_XOR: alu = a ^ b;
         default: alu = '0;
      endcase
   endfunction

   assign free       = ~busy;
   assign free_pick  = free & (~free + NUM_RS'(1));
   assign ready_pick = ready & (~ready + NUM_RS'(1));
   assign own_valid  = rts && bus.cdb_grant;
   assign issue_ok   = bus.issue && bus.execution_unit == ADDER && |free;
   assign alloc_vec  = issue_ok ? free_pick : '0;

   for (genvar i = 0; i < NUM_RS; i++) begin : g_rs
      rs_entry #(
         .NUM_RS(NUM_RS),
         .DATA_WIDTH(DATA_WIDTH),
         .REG_ADDR_BITS(REG_ADDR_BITS)
      ) u_rs (
         .clock(clock),
         .reset_n(reset_n),
         .alloc(alloc_vec[i]),
         .op(bus.operation[2:0]),
         .dest(bus.Dest_address),
         .a_value(bus.rf_A_value),
         .a_tag(bus.rf_A_tag),
         .b_value(bus.rf_B_value),
         .b_tag(bus.rf_B_tag),
         .ext_valid(bus.cdb_in_valid),
         .ext_tag(bus.cdb_in_tag),
         .ext_value(bus.cdb_in_value),
         .own_valid(own_valid),
         .own_tag(res_tag),
         .own_value(res_value),
         .dispatch(dispatch_vec[i]),
         .retire(retire_vec[i]),
         .busy(busy[i]),
         .ready(ready[i]),
         .alu_op(op_arr[i]),
         .dest_reg(dest_arr[i]),
         .vj(vj_arr[i]),
         .vk(vk_arr[i])
      );
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      ex_vj_n      = ex_vj;
      ex_vk_n      = ex_vk;
      ex_op_n      = ex_op;
      ex_tag_n     = ex_tag;
      ex_dest_n    = ex_dest;
      rts_n        = rts;
      res_tag_n    = res_tag;
      res_dest_n   = res_dest;
      res_value_n  = res_value;
      dispatch_vec = '0;
      retire_vec   = '0;
      unique case (state)
         IDLE: begin
            if (|ready) begin
               dispatch_vec = ready_pick;
               ex_tag_n     = ready_pick;
               cnt_n        = CW'(ADDER_LATENCY - 1);
               state_n      = EXEC;
               for (int i = 0; i < NUM_RS; i++) begin
                  if (ready_pick[i]) begin
                     ex_vj_n   = vj_arr[i];
                     ex_vk_n   = vk_arr[i];
                     ex_op_n   = op_arr[i];
                     ex_dest_n = dest_arr[i];
                  end
               end
            end
         end
         EXEC: begin
            if (cnt == '0) begin
               res_value_n = alu(ex_op, ex_vj, ex_vk);
               res_tag_n   = ex_tag;
               res_dest_n  = ex_dest;
               rts_n       = 1'b1;
               state_n     = WAIT_CDB;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         WAIT_CDB: begin
            if (bus.cdb_grant) begin
               retire_vec  = res_tag;
               rts_n       = 1'b0;
               res_tag_n   = '0;
               res_dest_n  = '0;
               res_value_n = '0;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         ex_vj     <= '0;
         ex_vk     <= '0;
         ex_op     <= '0;
         ex_tag    <= '0;
         ex_dest   <= '0;
         rts       <= 1'b0;
         res_tag   <= '0;
         res_dest  <= '0;
         res_value <= '0;
         issued_q  <= '0;
         exec_q    <= '0;
         fin_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         ex_vj     <= ex_vj_n;
         ex_vk     <= ex_vk_n;
         ex_op     <= ex_op_n;
         ex_tag    <= ex_tag_n;
         ex_dest   <= ex_dest_n;
         rts       <= rts_n;
         res_tag   <= res_tag_n;
         res_dest  <= res_dest_n;
         res_value <= res_value_n;
         issued_q  <= alloc_vec;
         exec_q    <= dispatch_vec;
         fin_q     <= retire_vec;
         err_q     <= bus.issue && !issue_ok;
      end
   end

   assign bus.adder_available    = |free;
   assign bus.adder_RS_available = free_pick;
   assign bus.RS_issued          = issued_q;
   assign bus.RS_executing_adder = exec_q;
   assign bus.adder_rts          = rts;
   assign bus.cdb_tag            = res_tag;
   assign bus.cdb_dest           = res_dest;
   assign bus.cdb_value          = res_value;
   assign bus.RS_finished        = fin_q;
   assign bus.issue_error        = err_q;

   // Source addresses feed the external register-status lookup only.
   assign unused_bits = ^{bus.A_address, bus.B_address, bus.operation[5:3]};
endmodule
